// File: rtl/reg_write_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// reg_write_scheduler_pkg
//
// Purpose : Shared definitions for the register write scheduler slice.
//           Holds the two-state scheduler enum, the default parameter values
//           and a small helper for sizing index fields.
//
// Contents:
//   state_e        - scheduler state (IDLE, GRANT)
//   N_REQ_DEFAULT  - default number of write requesters
//   N_REG_DEFAULT  - default number of registers in the controlled bank
//   DW_DEFAULT     - default register data width
//   idxWidth()     - width of an index field that selects one of n items
// ----------------------------------------------------------------------------
package reg_write_scheduler_pkg;

    // IDLE waits for a request, GRANT drives exactly one write for one cycle
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int N_REQ_DEFAULT = 4;
    localparam int N_REG_DEFAULT = 8;
    localparam int DW_DEFAULT    = 8;

    // A single-item selector still needs one bit so that vectors never
    // collapse to zero width
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_write_scheduler_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//
// Purpose : Purely combinational round-robin pick. Starting at index ptr and
//           wrapping modulo N_REQ, reports the first requester whose req bit
//           is high.
//
// Ports   :
//   req     in  [N_REQ-1:0]  request vector
//   ptr     in  [IW-1:0]     index at which the search begins
//   winner  out [IW-1:0]     index of the selected requester (0 when none)
//   valid   out              at least one request is pending
// ----------------------------------------------------------------------------
module rr_arbiter
    import reg_write_scheduler_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEFAULT,
    localparam int IW    = idxWidth(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    winner,
    output logic             valid
);

    // Walk the offsets from farthest to nearest so the requester closest to
    // ptr is the last one to overwrite the result and therefore wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N_REQ]) begin
                winner = IW'((int'(ptr) + k) % N_REQ);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_write_scheduler.sv
// ----------------------------------------------------------------------------
// reg_write_scheduler
//
// Purpose : Serialises writes from N_REQ requesters into a bank of N_REG
//           enabled-flop registers. A round-robin arbiter picks one request
//           in IDLE; the chosen index, address and data are latched and the
//           write is driven for exactly one GRANT cycle. A protection mask
//           can veto a write, in which case the grant still pulses and err
//           is raised instead of the register enable.
//
// Ports   :
//   clk       in                 single rising-edge clock
//   reset     in                 synchronous active-high reset
//   req       in  [N_REQ-1:0]    level requests, held until granted
//   req_addr  in  [N_REQ*AW-1:0] target register index per requester
//   req_data  in  [N_REQ*DW-1:0] write data per requester
//   gnt       out [N_REQ-1:0]    one-hot grant pulse during GRANT
//   err       out                granted write was blocked by protection
//   prot_we   in                 protection mask load strobe
//   prot_din  in  [N_REG-1:0]    new protection mask (1 = blocked)
//   reg_en    out [N_REG-1:0]    one-hot enable to the register bank
//   reg_din   out [DW-1:0]       data to the register bank
//   busy      out                high while in GRANT
// ----------------------------------------------------------------------------
module reg_write_scheduler
    import reg_write_scheduler_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEFAULT,
    parameter  int N_REG = N_REG_DEFAULT,
    parameter  int DW    = DW_DEFAULT,
    localparam int AW    = idxWidth(N_REG),
    localparam int IW    = idxWidth(N_REQ)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    gnt,
    output logic                err,
    input  logic                prot_we,
    input  logic [N_REG-1:0]    prot_din,
    output logic [N_REG-1:0]    reg_en,
    output logic [DW-1:0]       reg_din,
    output logic                busy
);

    state_e           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [N_REG-1:0] prot_q, prot_d;
    logic [IW-1:0]    win_q, win_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    data_q, data_d;

    logic [IW-1:0]    arbWinner;
    logic             arbValid;
    logic             addrInRange;
    logic             targetBlocked;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .req    (req),
        .ptr    (ptr_q),
        .winner (arbWinner),
        .valid  (arbValid)
    );

    // Next-state logic. The mask loads on every prot_we edge regardless of
    // state, so a load coinciding with IDLE->GRANT is already in prot_q
    // when the grant decision is made. The pointer only moves when a grant
    // is actually taken.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        addr_d  = addr_q;
        data_d  = data_q;
        prot_d  = prot_we ? prot_din : prot_q;

        case (state_q)
            IDLE: begin
                if (arbValid) begin
                    state_d = GRANT;
                    win_d   = arbWinner;
                    addr_d  = req_addr[int'(arbWinner) * AW +: AW];
                    data_d  = req_data[int'(arbWinner) * DW +: DW];
                    ptr_d   = (arbWinner == IW'(N_REQ - 1)) ? '0
                                                             : arbWinner + IW'(1);
                end
            end
            GRANT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Addresses past the end of a non-power-of-two bank have no register
    // behind them and are vetoed like a protected target.
    always_comb begin
        addrInRange   = (int'(addr_q) < N_REG);
        targetBlocked = addrInRange ? prot_q[addr_q] : 1'b1;
    end

    // Outputs come only from registered state, so there is no combinational
    // path from req to gnt. reg_din follows the latched data, which only
    // changes on entry to GRANT and therefore holds between writes.
    always_comb begin
        gnt     = '0;
        reg_en  = '0;
        err     = 1'b0;
        busy    = (state_q == GRANT);
        reg_din = data_q;
        if (state_q == GRANT) begin
            gnt[win_q] = 1'b1;
            if (targetBlocked) begin
                err = 1'b1;
            end else begin
                reg_en[addr_q] = 1'b1;
            end
        end
    end

    // State registers. Reset wins over every other input and, when it lands
    // on a GRANT cycle, drops the pending write without a further pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            prot_q  <= '0;
            win_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            prot_q  <= prot_d;
            win_q   <= win_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: doc/reg_write_scheduler.md
REG_WRITE_SCHEDULER -- requirements
Module: reg_write_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of write requesters.
REQ-002 Parameter N_REG, default 8, number of enabled-flop registers in the controlled bank.
REQ-003 Parameter DW, default 8, register data width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-006 req  input  N_REQ  per-requester write request, level, held until granted.
REQ-007 req_addr  input  N_REQ*$clog2(N_REG)  per-requester target register index, slice i belongs to requester i.
REQ-008 req_data  input  N_REQ*DW  per-requester write data, slice i belongs to requester i.
REQ-009 gnt  output  N_REQ  one-hot grant pulse, one cycle.
REQ-010 err  output  1  one-cycle pulse: granted write was blocked by protection.
REQ-011 prot_we  input  1  protection-mask load strobe.
REQ-012 prot_din  input  N_REG  new protection mask; bit k=1 blocks writes to register k.
REQ-013 reg_en  output  N_REG  one-hot enable to the register bank.
REQ-014 reg_din  output  DW  data to the register bank.
REQ-015 busy  output  1  high while state is GRANT.

Function
REQ-016 FSM states IDLE and GRANT only.
REQ-017 IDLE: if any req bit is high, latch the winner index, its addr and data, advance to GRANT; else remain IDLE.
REQ-018 GRANT: lasts exactly one cycle, then IDLE unconditionally.
REQ-019 In GRANT: gnt[winner]=1; reg_din=latched data; reg_en[latched addr]=1 unless prot[latched addr]=1.
REQ-020 Protected target in GRANT: gnt still pulses, reg_en all zero, err=1.
REQ-021 Outside GRANT: gnt, reg_en, err all zero; reg_din holds last value.
REQ-022 Latency: req sampled high at edge t -> gnt/reg_en high during cycle t+1 -> bank captures at edge t+2.
REQ-023 Maximum throughput: one write per two cycles.
REQ-024 Requester deasserts req on the edge at which its gnt is high; the scheduler need not mask a stale req.
REQ-025 Round-robin: search starts at index ptr, wraps modulo N_REQ; after granting i, ptr=(i+1) mod N_REQ.
REQ-026 Wrap-around: grant to N_REQ-1 sets ptr=0.
REQ-027 Non-requesting indices never move ptr; ptr updates only on entering GRANT.
REQ-028 Protection mask register loads prot_din on any edge with prot_we=1, in either state.
REQ-029 Simultaneous prot_we and IDLE->GRANT: the decision in GRANT uses the newly loaded mask.
REQ-030 req_addr >= N_REG (non-power-of-two N_REG): treated as protected, err=1, no reg_en.

Reset
REQ-031 reset=1 at an edge: state=IDLE, ptr=0, prot mask=all zero, latched winner/addr/data=0.
REQ-032 Outputs during and after reset: gnt=0, reg_en=0, reg_din=0, err=0, busy=0.
REQ-033 reset asserted during GRANT aborts the grant; no further reg_en or gnt pulse for that request.
REQ-034 reset has priority over prot_we and req.

Structure
REQ-035 Shared package holds the state enum (IDLE, GRANT) and default parameter constants.
REQ-036 One sub-module, rr_arbiter: combinational round-robin pick from req and ptr, outputs winner index and valid.
REQ-037 All sequential logic lives in reg_write_scheduler; no latches; no combinational path from req to gnt.

Verification
REQ-038 Single request: req=0001, addr0=3, data0=0xA5 -> next cycle gnt=0001, reg_en=0x08, reg_din=0xA5, busy=1.
REQ-039 All four request continuously (each re-raises after grant) from reset -> grant order 0,1,2,3,0, one grant per two cycles.
REQ-040 Protection: prot_we with prot_din=0x04, then req1 addr=2 data=0x3C -> gnt=0010, reg_en=0, err=1.
REQ-041 Wrap: last grant to requester 3, then req=1001 -> grant 0 before 3.
REQ-042 Reset mid-GRANT: reset high in GRANT cycle -> next cycle gnt=0, reg_en=0, ptr=0, mask=0.
REQ-043 Simultaneous prot_we (0x01) with req2 addr=0 sampled in IDLE -> gnt=0100, reg_en=0, err=1.
